// File: rtl/aes_fifo_host_driver_pkg.sv
// Shared definitions for the AES FIFO host driver: end-of-batch marker,
// FSM encoding and status bit positions for the host register map.
package aes_fifo_host_driver_pkg;

   localparam logic [31:0] TERM_WORD = 32'h11110fff;
   localparam int unsigned STAGE_W   = 16;

   localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
   localparam logic [2:0] ST_SEND_ENC      = 3'd1;
   localparam logic [2:0] ST_SEND_TERM_ENC = 3'd2;
   localparam logic [2:0] ST_COLLECT_ENC   = 3'd3;
   localparam logic [2:0] ST_FINISH_ENC    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = ST_IDLE_ENC,
      ST_SEND      = ST_SEND_ENC,
      ST_SEND_TERM = ST_SEND_TERM_ENC,
      ST_COLLECT   = ST_COLLECT_ENC,
      ST_FINISH    = ST_FINISH_ENC
   } drv_state_e;

   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;
   localparam int unsigned STAT_ERR_BIT  = 2;

   // Status word as seen by the host register decode.
   function automatic logic [2:0] pack_status(input logic busy, input logic done, input logic err);
      logic [2:0] s;
      s = 3'b000;
      s[STAT_BUSY_BIT] = busy;
      s[STAT_DONE_BIT] = done;
      s[STAT_ERR_BIT]  = err;
      return s;
   endfunction

endpackage

// File: rtl/aes_drv_buffer.sv
// Simple dual-port RAM, one write port and one registered read port.
// Memory contents are not reset; only the read register is.
module aes_drv_buffer #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) rd_data <= '0;
      else          rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/aes_fifo_host_driver.sv
// Host-side driver for the AES FIFO pair: streams staged key/data pairs plus a
// terminator into the input FIFO, then collects the results into a buffer.
module aes_fifo_host_driver
   import aes_fifo_host_driver_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned ADDR_W         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cfg_wr,
   input  logic [ADDR_W-1:0]     cfg_addr,
   input  logic [15:0]           cfg_wdata,
   input  logic                  start,
   input  logic [ADDR_W:0]       start_count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic [ADDR_W-1:0]     res_addr,
   output logic [DATA_WIDTH-1:0] res_data,
   input  logic                  tx_full,
   output logic                  tx_wr,
   output logic [DATA_WIDTH-1:0] tx_dout,
   input  logic                  rx_empty,
   output logic                  rx_rd,
   input  logic [DATA_WIDTH-1:0] rx_din
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   drv_state_e          state;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    tx_idx;
   logic [CNT_W-1:0]    rx_idx;
   logic [TO_W-1:0]     to_cnt;
   logic [STAGE_W-1:0]  stage_rd;
   logic [ADDR_W-1:0]   stage_rd_addr;
   logic                stage_wr;
   logic                start_ok;

   assign stage_wr = cfg_wr && (state == ST_IDLE);
   assign start_ok = (start_count != '0) && (start_count <= CNT_W'(DEPTH));

   aes_drv_buffer #(.WIDTH(STAGE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (stage_wr),
      .wr_addr (cfg_addr),
      .wr_data (cfg_wdata),
      .rd_addr (stage_rd_addr),
      .rd_data (stage_rd)
   );

   aes_drv_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_result (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (rx_rd),
      .wr_addr (rx_idx[ADDR_W-1:0]),
      .wr_data (rx_din),
      .rd_addr (res_addr),
      .rd_data (res_data)
   );

   // FIFO handshakes; staging read address runs one word ahead so SEND streams every cycle.
   always_comb begin
      tx_wr         = 1'b0;
      rx_rd         = 1'b0;
      tx_dout       = '0;
      stage_rd_addr = '0;
      case (state)
         ST_SEND: begin
            tx_wr         = !tx_full;
            tx_dout       = DATA_WIDTH'(stage_rd);
            stage_rd_addr = ADDR_W'(tx_wr ? tx_idx + CNT_W'(1) : tx_idx);
         end
         ST_SEND_TERM: begin
            tx_wr   = !tx_full;
            tx_dout = DATA_WIDTH'(TERM_WORD);
         end
         ST_COLLECT: rx_rd = !rx_empty;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         count  <= '0;
         tx_idx <= '0;
         rx_idx <= '0;
         to_cnt <= '0;
      end else if (abort && (state != ST_IDLE)) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b1;
         err   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  if (start_ok) begin
                     state  <= ST_SEND;
                     busy   <= 1'b1;
                     done   <= 1'b0;
                     err    <= 1'b0;
                     count  <= start_count;
                     tx_idx <= '0;
                     rx_idx <= '0;
                  end else begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (tx_wr) begin
                  tx_idx <= tx_idx + CNT_W'(1);
                  if (tx_idx == count - CNT_W'(1)) state <= ST_SEND_TERM;
               end
            end
            ST_SEND_TERM: begin
               if (tx_wr) begin
                  state  <= ST_COLLECT;
                  to_cnt <= '0;
               end
            end
            ST_COLLECT: begin
               if (rx_rd) begin
                  rx_idx <= rx_idx + CNT_W'(1);
                  to_cnt <= '0;
                  if (rx_idx == count - CNT_W'(1)) begin
                     state <= ST_FINISH;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  state <= ST_FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_fifo_host_driver.sv
// Scoreboard bench for aes_fifo_host_driver: expected tx words are queued by the
// stimulus, a negedge monitor pops and compares each word the DUT writes.
module tb_aes_fifo_host_driver;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned TO    = 16;
   localparam logic [31:0] TERM  = 32'h11110fff;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          cfg_wr;
   logic [AW-1:0] cfg_addr;
   logic [15:0]   cfg_wdata;
   logic          start;
   logic [AW:0]   start_count;
   logic          abort;
   logic          busy, done, err;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_data;
   logic          tx_full;
   logic          tx_wr;
   logic [DW-1:0] tx_dout;
   logic          rx_empty = 1'b1;
   logic          rx_rd;
   logic [DW-1:0] rx_din = '0;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int tx_cnt = 0;
   int rx_cnt = 0;
   int busy_seen = 0;
   int pop_edge = 0;
   logic rx_pop_s = 1'b0;
   logic [31:0] exp_tx[$];
   logic [31:0] rx_src[$];
   int tx_cyc[$];
   logic [15:0] stage_m[DEPTH];

   aes_fifo_host_driver #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .start(start), .start_count(start_count), .abort(abort),
      .busy(busy), .done(done), .err(err), .res_addr(res_addr), .res_data(res_data),
      .tx_full(tx_full), .tx_wr(tx_wr), .tx_dout(tx_dout), .rx_empty(rx_empty),
      .rx_rd(rx_rd), .rx_din(rx_din)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every word the DUT commits to the input FIFO.
   always @(negedge clock) begin
      if (busy === 1'b1) busy_seen++;
      if (tx_full === 1'b1) check("tx_wr_while_full", {31'd0, tx_wr}, 32'd0);
      if (rx_rd === 1'b1 && rx_empty === 1'b1) check("rx_rd_while_empty", {31'd0, rx_rd}, 32'd0);
      if (tx_wr === 1'b1) begin
         tx_cnt++;
         tx_cyc.push_back(cyc);
         if (exp_tx.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tx_unexpected: got %h with no word expected", tx_dout);
         end else begin
            check("tx_word", tx_dout, exp_tx.pop_front());
         end
      end
      if (rx_rd === 1'b1) begin
         rx_cnt++;
         pop_edge = cyc + 1;
      end
      rx_pop_s = rx_rd;
   end

   // Output FIFO model (first-word-fall-through).
   always @(posedge clock) begin
      #2;
      if (rx_pop_s && rx_src.size() > 0) void'(rx_src.pop_front());
      rx_empty = (rx_src.size() == 0);
      rx_din   = (rx_src.size() > 0) ? rx_src[0] : 32'h0;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input int idx, input logic [15:0] val);
      cfg_wr = 1'b1; cfg_addr = AW'(idx); cfg_wdata = val;
      tick();
      cfg_wr = 1'b0;
      stage_m[idx] = val;
   endtask

   task automatic expect_batch(input int n);
      for (int i = 0; i < n; i++) exp_tx.push_back({16'h0000, stage_m[i]});
      exp_tx.push_back(TERM);
   endtask

   task automatic pulse_start(input int n);
      start = 1'b1; start_count = (AW+1)'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin tick(); n++; end
      check(name, {31'd0, done}, 32'd1);
      tick();
   endtask

   task automatic read_res(input string name, input int addr, input logic [31:0] exp);
      res_addr = AW'(addr);
      tick();
      check(name, res_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0, n;
      reset_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
      start_count = '0; abort = 1'b0; res_addr = '0; tx_full = 1'b0;
      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
      check("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
      check("rst_tx_dout", tx_dout, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      reset_n = 1'b1;
      tick();

      // start_count = 0 is rejected
      busy_seen = 0;
      pulse_start(0);
      check("bad0_err", {31'd0, err}, 32'd1);
      check("bad0_done", {31'd0, done}, 32'd1);
      repeat (3) tick();
      check("bad0_no_tx", tx_cnt, 32'd0);
      check("bad0_no_busy", busy_seen, 32'd0);

      // basic three-pair batch
      load(0, 16'h2B32); load(1, 16'h7E88); load(2, 16'h1501);
      rx_src.push_back(32'h39); rx_src.push_back(32'h25); rx_src.push_back(32'h84);
      tick();
      tx_cyc.delete();
      expect_batch(3);
      pulse_start(3);
      wait_done("b1_done", 100);
      check("b1_err", {31'd0, err}, 32'd0);
      check("b1_busy", {31'd0, busy}, 32'd0);
      check("b1_tx_n", tx_cyc.size(), 32'd4);
      if (tx_cyc.size() == 4) check("b1_tx_back_to_back", tx_cyc[3] - tx_cyc[0], 32'd3);
      read_res("b1_res0", 0, 32'h39);
      read_res("b1_res1", 1, 32'h25);
      read_res("b1_res2", 2, 32'h84);

      // start_count = 17 is rejected
      base = tx_cnt; busy_seen = 0;
      pulse_start(17);
      check("bad17_err", {31'd0, err}, 32'd1);
      check("bad17_done", {31'd0, done}, 32'd1);
      repeat (3) tick();
      check("bad17_no_tx", tx_cnt - base, 32'd0);
      check("bad17_no_busy", busy_seen, 32'd0);

      // full-depth batch with a 5-cycle tx_full stall after the 4th word
      for (int i = 0; i < 16; i++) load(i, {4'(i), 4'hC, 8'(8'h10 + i)});
      for (int i = 0; i < 16; i++) rx_src.push_back(32'h0000_0100 + 32'(i));
      tick();
      base = tx_cnt; t0 = rx_cnt;
      expect_batch(16);
      pulse_start(16);
      n = 0;
      while (tx_cnt - base < 4 && n < 50) begin tick(); n++; end
      tx_full = 1'b1;
      repeat (5) tick();
      check("stall_tx_held", tx_cnt - base, 32'd4);
      tx_full = 1'b0;
      wait_done("b2_done", 200);
      check("b2_err", {31'd0, err}, 32'd0);
      check("b2_tx_n", tx_cnt - base, 32'd17);
      check("b2_pops", rx_cnt - t0, 32'd16);
      read_res("b2_res0", 0, 32'h100);
      read_res("b2_res15", 15, 32'h10F);

      // timeout: two pairs, one result word
      rx_src.push_back(32'hDEAD0001);
      tick();
      expect_batch(2);
      pulse_start(2);
      n = 0;
      while (err !== 1'b1 && n < 200) begin tick(); n++; end
      check("to_err_set", {31'd0, err}, 32'd1);
      check("to_latency", cyc - pop_edge, 32'd16);
      wait_done("to_done", 10);
      check("to_err_sticky", {31'd0, err}, 32'd1);
      read_res("to_res0", 0, 32'hDEAD0001);

      // abort two cycles into COLLECT
      base = rx_cnt;
      expect_batch(2);
      pulse_start(2);
      n = 0;
      while (exp_tx.size() != 0 && n < 50) begin tick(); n++; end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd1);
      check("abort_err", {31'd0, err}, 32'd1);
      check("abort_no_pops", rx_cnt - base, 32'd0);

      // abort and start together in IDLE: start ignored
      base = tx_cnt;
      abort = 1'b1; start = 1'b1; start_count = 5'd2;
      tick();
      abort = 1'b0; start = 1'b0;
      repeat (3) tick();
      check("abort_start_busy", {31'd0, busy}, 32'd0);
      check("abort_start_no_tx", tx_cnt - base, 32'd0);

      // reset in the middle of SEND
      expect_batch(16);
      pulse_start(16);
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_done", {31'd0, done}, 32'd0);
      check("mrst_err", {31'd0, err}, 32'd0);
      check("mrst_tx_wr", {31'd0, tx_wr}, 32'd0);
      check("mrst_tx_dout", tx_dout, 32'd0);
      check("mrst_res_data", res_data, 32'd0);
      reset_n = 1'b1;
      exp_tx.delete();
      tick();
      rx_src.push_back(32'hA1); rx_src.push_back(32'hB2);
      tick();
      expect_batch(2);
      pulse_start(2);
      wait_done("post_rst_done", 100);
      check("post_rst_err", {31'd0, err}, 32'd0);
      read_res("post_rst_res1", 1, 32'hB2);

      // cfg_wr and start while busy are ignored
      load(5, 16'h5A5A);
      for (int i = 0; i < 6; i++) rx_src.push_back(32'h200 + 32'(i));
      tick();
      base = tx_cnt;
      expect_batch(6);
      pulse_start(6);
      cfg_wr = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'hFFFF;
      start = 1'b1; start_count = 5'd3;
      tick();
      cfg_wr = 1'b0; start = 1'b0;
      wait_done("busy_cfg_done", 100);
      check("busy_start_tx_n", tx_cnt - base, 32'd7);
      for (int i = 0; i < 6; i++) rx_src.push_back(32'h300 + 32'(i));
      tick();
      expect_batch(6);
      pulse_start(6);
      wait_done("stage5_done", 100);
      check("stage5_err", {31'd0, err}, 32'd0);
      read_res("stage5_res5", 5, 32'h305);

      check("sb_drained", exp_tx.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
